// File: rtl/if_stage.sv
// Fetch stage: PC, in-order instruction-memory requests, 2-entry response FIFO and IF/ID register.
// Build option: define IF_BUBBLE_NOP_EN to load addi x0,x0,0 / pc 0 into IF/ID on every bubble.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
);

    localparam logic [2:0] Depth = 3'(DEPTH);

`ifdef IF_BUBBLE_NOP_EN
    localparam logic [31:0] BubbleInstr = 32'h0000_0013;
    localparam logic [31:0] IdInstrRst  = BubbleInstr;
`else
    localparam logic [31:0] IdInstrRst  = 32'h0000_0000;
`endif

    // Program counter and request bookkeeping
    logic [31:0] pc_q, pc_d;
    logic [1:0]  inflight_q, inflight_d;
    logic [1:0]  drop_q, drop_d;

    // Response FIFO
    logic [1:0]  fifo_cnt_q, fifo_cnt_d;
    logic        fifo_rd_q, fifo_rd_d;
    logic        fifo_wr_q, fifo_wr_d;
    logic [31:0] fifo_pc_q    [DEPTH];
    logic [31:0] fifo_instr_q [DEPTH];

    // Per-request address queue; holds the PCs of live (non-dropped) requests
    logic        aq_rd_q, aq_rd_d;
    logic        aq_wr_q, aq_wr_d;
    logic [31:0] aq_pc_q [DEPTH];

    // IF/ID pipeline register
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;

    logic        grant;
    logic        resp_drop;
    logic        push;
    logic        pop;
    logic [2:0]  live;
    logic [2:0]  credit;

    assign grant     = imem_req & imem_gnt;
    assign resp_drop = imem_rvalid & (drop_q != 2'd0);
    assign push      = imem_rvalid & ~resp_drop & ~flush;
    assign pop       = ~stall & (fifo_cnt_q != 2'd0);

    // A new request is allowed only if its response is guaranteed a FIFO slot,
    // counting what is buffered plus what is still coming back, minus this cycle's pop.
    assign live      = {1'b0, inflight_q} - {1'b0, drop_q};
    assign credit    = {1'b0, fifo_cnt_q} + live - {2'b00, pop};
    assign imem_req  = ~rst & ~flush & ({1'b0, inflight_q} < Depth) & (credit < Depth);
    assign imem_addr = pc_q;

    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_instr  = id_instr_q;

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q + {1'b0, grant} - {1'b0, imem_rvalid};
        drop_d     = drop_q;
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        fifo_rd_d  = fifo_rd_q ^ pop;
        fifo_wr_d  = fifo_wr_q ^ push;
        aq_rd_d    = aq_rd_q ^ push;
        aq_wr_d    = aq_wr_q ^ grant;

        if (flush) begin
            pc_d       = redirect_pc;
            // Everything still outstanding, except a response landing right now, must be discarded.
            drop_d     = inflight_q - {1'b0, imem_rvalid};
            fifo_cnt_d = 2'd0;
            fifo_rd_d  = 1'b0;
            fifo_wr_d  = 1'b0;
            aq_rd_d    = 1'b0;
            aq_wr_d    = 1'b0;
        end else begin
            if (grant) begin
                pc_d = pc_q + 32'd4;
            end
            if (resp_drop) begin
                drop_d = drop_q - 2'd1;
            end
        end
    end

    always_comb begin
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;

        if (flush) begin
            id_valid_d = 1'b0;
`ifdef IF_BUBBLE_NOP_EN
            id_pc_d    = 32'h0000_0000;
            id_instr_d = BubbleInstr;
`endif
        end else if (!stall) begin
            id_valid_d = pop;
            if (pop) begin
                id_pc_d    = fifo_pc_q[fifo_rd_q];
                id_instr_d = fifo_instr_q[fifo_rd_q];
            end
`ifdef IF_BUBBLE_NOP_EN
            else begin
                id_pc_d    = 32'h0000_0000;
                id_instr_d = BubbleInstr;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= 2'd0;
            drop_q     <= 2'd0;
            fifo_cnt_q <= 2'd0;
            fifo_rd_q  <= 1'b0;
            fifo_wr_q  <= 1'b0;
            aq_rd_q    <= 1'b0;
            aq_wr_q    <= 1'b0;
            id_valid_q <= 1'b0;
            id_pc_q    <= 32'h0000_0000;
            id_instr_q <= IdInstrRst;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            fifo_cnt_q <= fifo_cnt_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            aq_rd_q    <= aq_rd_d;
            aq_wr_q    <= aq_wr_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
        end
    end

    // Storage arrays need no reset: occupancy is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (grant) begin
            aq_pc_q[aq_wr_q] <= pc_q;
        end
        if (push) begin
            fifo_pc_q[fifo_wr_q]    <= aq_pc_q[aq_rd_q];
            fifo_instr_q[fifo_wr_q] <= imem_rdata;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && fifo_cnt_q == Depth[1:0]))
                else $error("if_stage: push into full fetch FIFO");
            assert (drop_q <= inflight_q)
                else $error("if_stage: drop count exceeds in-flight count");
            assert (!(imem_rvalid && inflight_q == 2'd0))
                else $error("if_stage: response with no request in flight");
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: memory model with configurable latency plus a scoreboard
// of expected {pc, instr} pairs pushed on each grant and popped when IF/ID presents a new instruction.
module tb_if_stage;

    localparam logic [31:0] ResetPc = 32'h0000_0000;
`ifdef IF_BUBBLE_NOP_EN
    localparam logic [31:0] IdInstrRst = 32'h0000_0013;
`else
    localparam logic [31:0] IdInstrRst = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC (ResetPc),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_instr    (id_instr)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct packed {
        int          due;
        logic [31:0] addr;
    } mem_t;

    exp_t        exp_q[$];
    mem_t        mem_q[$];
    int          cyc;
    int          lat;
    int          n_checks;
    int          n_pass;
    int          grants;
    int          id_seen;
    int          first_grant_cyc;
    int          first_id_cyc;
    logic [31:0] exp_fetch_pc;
    logic        prev_rst;
    logic        prev_flush;
    logic        prev_stall;
    logic        last_valid;
    logic [31:0] last_pc;
    logic [31:0] last_instr;
    logic        last_req;
    logic [31:0] last_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h0010_0113;
        return {a[21:2], 12'h033};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // One clock cycle: observe IF/ID, drive inputs, then sample the request side.
    task automatic step(input logic r, input logic s, input logic f, input logic [31:0] rd,
                        input logic g);
        exp_t e;
        mem_t m;
        @(negedge clk);
        cyc++;
        if (prev_rst) begin
            check("rst_id_valid", {31'b0, id_valid}, 32'h0);
            check("rst_id_pc", id_pc, 32'h0);
            check("rst_id_instr", id_instr, IdInstrRst);
        end else if (prev_flush) begin
            check("flush_id_valid", {31'b0, id_valid}, 32'h0);
`ifdef IF_BUBBLE_NOP_EN
            check("flush_id_pc", id_pc, 32'h0);
            check("flush_id_instr", id_instr, 32'h0000_0013);
`else
            check("flush_id_pc_hold", id_pc, last_pc);
            check("flush_id_instr_hold", id_instr, last_instr);
`endif
        end else if (prev_stall) begin
            check("stall_valid_hold", {31'b0, id_valid}, {31'b0, last_valid});
            check("stall_pc_hold", id_pc, last_pc);
            check("stall_instr_hold", id_instr, last_instr);
        end else if (id_valid) begin
            check("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'h1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("id_pc", id_pc, e.pc);
                check("id_instr", id_instr, e.instr);
            end
            id_seen++;
            if (first_id_cyc < 0) first_id_cyc = cyc;
        end
        last_valid = id_valid;
        last_pc    = id_pc;
        last_instr = id_instr;

        rst         = r;
        stall       = s;
        flush       = f;
        redirect_pc = rd;
        imem_gnt    = g;
        if (r) begin
            mem_q.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hdead_beef;
        end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            m = mem_q.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(m.addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hdead_beef;
        end

        #1;
        last_req  = imem_req;
        last_addr = imem_addr;
        if (r || f) begin
            check("req_off", {31'b0, imem_req}, 32'h0);
        end else if (imem_req && imem_gnt) begin
            check("imem_addr", imem_addr, exp_fetch_pc);
            m.due  = cyc + lat;
            m.addr = imem_addr;
            mem_q.push_back(m);
            e.pc    = exp_fetch_pc;
            e.instr = mem_word(exp_fetch_pc);
            exp_q.push_back(e);
            exp_fetch_pc = exp_fetch_pc + 32'd4;
            grants++;
            if (first_grant_cyc < 0) first_grant_cyc = cyc;
        end
        if (r) begin
            exp_q.delete();
            exp_fetch_pc = ResetPc;
        end else if (f) begin
            exp_q.delete();
            exp_fetch_pc = rd;
        end
        prev_rst   = r;
        prev_flush = f;
        prev_stall = s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   g0;
        int   s0;
        int   waited;
        logic sr;
        logic fr;
        logic gr;

        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        cyc = 0; lat = 1; n_checks = 0; n_pass = 0; grants = 0; id_seen = 0;
        exp_fetch_pc = ResetPc; prev_rst = 1'b0; prev_flush = 1'b0; prev_stall = 1'b0;
        last_valid = 1'b0; last_pc = 32'h0; last_instr = 32'h0; last_req = 1'b0;
        last_addr = 32'h0;

        // Reset and first fetches with a 1-cycle memory
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        first_grant_cyc = -1;
        first_id_cyc    = -1;
        g0 = grants;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("t1_back_to_back_grants", grants - g0, 3);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("t1_first_id_latency", first_id_cyc - first_grant_cyc, 3);

        // Stall mid-stream
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t2_req_low_while_stalled", {31'b0, last_req}, 32'h0);
        s0 = id_seen;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("t2_resumed", {31'b0, id_seen > s0}, 32'h1);

        // Flush with 2-cycle memory and two requests in flight
        lat = 2;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        waited = 0;
        while (mem_q.size() != 2 && waited < 20) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            waited++;
        end
        check("t3_two_inflight", mem_q.size(), 2);
        step(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
        s0 = id_seen;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("t3_progress_after_flush", {31'b0, id_seen > s0}, 32'h1);

        // Flush and stall together while a response lands
        waited = 0;
        while (!(mem_q.size() != 0 && mem_q[0].due <= cyc + 1) && waited < 20) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            waited++;
        end
        check("t4_rvalid_pending", {31'b0, mem_q.size() != 0 && mem_q[0].due <= cyc + 1}, 32'h1);
        step(1'b0, 1'b1, 1'b1, 32'h200, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("t4_req_after_flush", {31'b0, last_req}, 32'h1);
        check("t4_addr_after_flush", last_addr, 32'h200);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Reset mid-operation, then grant backpressure at pc 0x20
        lat = 1;
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        waited = 0;
        while (exp_fetch_pc != 32'h20 && waited < 30) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            waited++;
        end
        check("t5_reached_0x20", exp_fetch_pc, 32'h20);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            check("t5_req_held", {31'b0, last_req}, 32'h1);
            check("t5_addr_held", last_addr, 32'h20);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Mixed random stall / grant / flush traffic on a 2-cycle memory
        lat = 2;
        for (int i = 0; i < 120; i++) begin
            sr = ($urandom_range(0, 3) == 0);
            fr = ($urandom_range(0, 15) == 0);
            gr = ($urandom_range(0, 3) != 0);
            step(1'b0, sr, fr, 32'h400 + 32'($urandom_range(0, 63)) * 32'd4, gr);
        end
        s0 = id_seen;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("final_progress", {31'b0, id_seen > s0}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
